// File: rtl/amber_uart_pkg.sv
// Shared definitions for the UART Wishbone master: FSM states, UART register
// offsets and flag-register bit positions.
package amber_uart_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        POLL,
        DECIDE,
        RD_DR,
        WR_DR,
        GAP
    } state_t;

    localparam logic [15:0] UART_DR = 16'h0000;
    localparam logic [15:0] UART_CR = 16'h0014;
    localparam logic [15:0] UART_FR = 16'h0018;

    localparam int unsigned FR_TXFE = 7;
    localparam int unsigned FR_RXFF = 6;
    localparam int unsigned FR_TXFF = 5;
    localparam int unsigned FR_RXFE = 4;
    localparam int unsigned FR_BUSY = 3;
    localparam int unsigned FR_CTS  = 0;

    function automatic logic [31:0] reg_adr(input logic [31:0] base, input logic [15:0] off);
        return base + 32'(off);
    endfunction

endpackage

// File: rtl/wb_single_txn.sv
// Runs one Wishbone classic cycle per start request; ends on ack, err or
// timeout and reports completion combinationally in the ending cycle.
module wb_single_txn #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned SWIDTH  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       adr,
    input  logic              we,
    input  logic [DWIDTH-1:0] wdata,
    output logic [31:0]       wb_adr,
    output logic [SWIDTH-1:0] wb_sel,
    output logic              wb_we,
    output logic [DWIDTH-1:0] wb_dat_w,
    output logic              wb_cyc,
    output logic              wb_stb,
    input  logic [DWIDTH-1:0] wb_dat_r,
    input  logic              wb_ack,
    input  logic              wb_err,
    output logic              done_c,
    output logic              err_c,
    output logic [DWIDTH-1:0] rdata_c
);

    logic [7:0] cnt;
    logic       expired_c;

    // cnt is 1 in the first strobe cycle, so stb stays high for TIMEOUT cycles
    assign expired_c = (cnt == 8'(TIMEOUT));
    assign done_c    = wb_stb && (wb_ack || wb_err || expired_c);
    assign err_c     = wb_stb && (wb_err || (expired_c && !wb_ack));
    assign rdata_c   = wb_dat_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_adr   <= 32'h0;
            wb_sel   <= '0;
            wb_we    <= 1'b0;
            wb_dat_w <= '0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            cnt      <= 8'd0;
        end else if (wb_cyc) begin
            if (done_c) begin
                wb_cyc <= 1'b0;
                wb_stb <= 1'b0;
            end else begin
                cnt <= 8'(cnt + 8'd1);
            end
        end else if (start) begin
            wb_adr   <= adr;
            wb_sel   <= '1;
            wb_we    <= we;
            wb_dat_w <= wdata;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            cnt      <= 8'd1;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// Wishbone initiator that configures the UART, polls its flags and moves bytes
// between the UART data register and a one-entry TX/RX client interface.
module uart_wb_master
    import amber_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADR  = 32'h1600_0000,
    parameter int unsigned WB_DWIDTH = 32,
    parameter int unsigned WB_SWIDTH = 4,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_valid,
    input  logic [7:0]           i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_rx_valid,
    output logic [7:0]           o_rx_data,
    input  logic                 i_rx_ready,
    output logic [31:0]          o_wb_adr,
    output logic [WB_SWIDTH-1:0] o_wb_sel,
    output logic                 o_wb_we,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    output logic                 o_err
);

    state_t               state, state_n;
    logic [7:0]           gap_cnt;
    logic [7:0]           tx_byte;
    logic                 fr_rxfe, fr_txff;
    logic                 start_c, req_we_c;
    logic [31:0]          req_adr_c;
    logic [WB_DWIDTH-1:0] req_dat_c;
    logic                 done_c, err_c;
    logic [WB_DWIDTH-1:0] rdata_c;
    logic                 unused_c;

    assign unused_c = ^rdata_c[WB_DWIDTH-1:8];

    wb_single_txn #(
        .DWIDTH (WB_DWIDTH),
        .SWIDTH (WB_SWIDTH),
        .TIMEOUT(TIMEOUT)
    ) u_txn (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (start_c),
        .adr     (req_adr_c),
        .we      (req_we_c),
        .wdata   (req_dat_c),
        .wb_adr  (o_wb_adr),
        .wb_sel  (o_wb_sel),
        .wb_we   (o_wb_we),
        .wb_dat_w(o_wb_dat),
        .wb_cyc  (o_wb_cyc),
        .wb_stb  (o_wb_stb),
        .wb_dat_r(i_wb_dat),
        .wb_ack  (i_wb_ack),
        .wb_err  (i_wb_err),
        .done_c  (done_c),
        .err_c   (err_c),
        .rdata_c (rdata_c)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= INIT;
        else          state <= state_n;
    end

    // Requests are issued one cycle before the state that owns the bus cycle
    always_comb begin
        state_n   = state;
        start_c   = 1'b0;
        req_we_c  = 1'b0;
        req_adr_c = reg_adr(BASE_ADR, UART_FR);
        req_dat_c = '0;
        case (state)
            INIT: begin
                if (!o_wb_cyc) begin
                    start_c   = 1'b1;
                    req_we_c  = 1'b1;
                    req_adr_c = reg_adr(BASE_ADR, UART_CR);
                end
                if (done_c) state_n = IDLE;
            end
            IDLE: begin
                start_c = 1'b1;
                state_n = POLL;
            end
            POLL: if (done_c) state_n = err_c ? GAP : DECIDE;
            DECIDE: begin
                req_adr_c = reg_adr(BASE_ADR, UART_DR);
                if (!fr_rxfe && !o_rx_valid) begin
                    start_c = 1'b1;
                    state_n = RD_DR;
                end else if (!o_tx_ready && !fr_txff) begin
                    start_c   = 1'b1;
                    req_we_c  = 1'b1;
                    req_dat_c = WB_DWIDTH'(tx_byte);
                    state_n   = WR_DR;
                end else begin
                    state_n = GAP;
                end
            end
            RD_DR, WR_DR: if (done_c) state_n = err_c ? GAP : IDLE;
            GAP: if (gap_cnt == 8'(POLL_GAP - 1)) state_n = IDLE;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            gap_cnt    <= 8'd0;
            fr_rxfe    <= 1'b1;
            fr_txff    <= 1'b1;
            tx_byte    <= 8'h0;
            o_tx_ready <= 1'b1;
            o_rx_valid <= 1'b0;
            o_rx_data  <= 8'h0;
            o_err      <= 1'b0;
        end else begin
            gap_cnt <= (state == GAP) ? 8'(gap_cnt + 8'd1) : 8'd0;
            if (state == POLL && done_c && !err_c) begin
                fr_rxfe <= rdata_c[FR_RXFE];
                fr_txff <= rdata_c[FR_TXFF];
            end
            // A failed DR write leaves the byte held for a retry
            if (i_tx_valid && o_tx_ready) begin
                tx_byte    <= i_tx_data;
                o_tx_ready <= 1'b0;
            end else if (state == WR_DR && done_c && !err_c) begin
                o_tx_ready <= 1'b1;
            end
            if (state == RD_DR && done_c && !err_c) begin
                o_rx_data  <= rdata_c[7:0];
                o_rx_valid <= 1'b1;
            end else if (i_rx_ready && o_rx_valid) begin
                o_rx_valid <= 1'b0;
            end
            if (err_c) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master with a one-wait Wishbone UART slave model.
module tb_uart_wb_master;

    localparam logic [31:0] A_DR = 32'h1600_0000;
    localparam logic [31:0] A_CR = 32'h1600_0014;
    localparam logic [31:0] A_FR = 32'h1600_0018;

    logic        clk, rst_n;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, dut_err;
    logic [7:0]  tx_data, rx_data;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0] wb_rdat = 32'h0;
    logic        wb_ack, wb_err, nack_dr_wr;
    logic [31:0] fr_default, dr_val;
    logic [31:0] fr_queue[$];

    int n_assert = 0;
    int n_fail   = 0;

    uart_wb_master dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tx_valid(tx_valid),
        .i_tx_data (tx_data),
        .o_tx_ready(tx_ready),
        .o_rx_valid(rx_valid),
        .o_rx_data (rx_data),
        .i_rx_ready(rx_ready),
        .o_wb_adr  (o_wb_adr),
        .o_wb_sel  (o_wb_sel),
        .o_wb_we   (o_wb_we),
        .o_wb_dat  (o_wb_dat),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .i_wb_dat  (wb_rdat),
        .i_wb_ack  (wb_ack),
        .i_wb_err  (wb_err),
        .o_err     (dut_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: acks the cycle after stb; FR reads pop scripted values first
    always @(posedge clk) begin
        if (!rst_n || !o_wb_cyc || wb_ack) begin
            wb_ack <= 1'b0;
        end else if (o_wb_stb && !(nack_dr_wr && o_wb_we && o_wb_adr == A_DR)) begin
            wb_ack <= 1'b1;
            if (o_wb_adr == A_FR) begin
                if (fr_queue.size() > 0) wb_rdat <= fr_queue.pop_front();
                else                     wb_rdat <= fr_default;
            end else begin
                wb_rdat <= dr_val;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input bit any_adr, input logic [31:0] adr, input bit any_we,
                            input logic we, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (o_wb_stb && wb_ack && (any_adr || o_wb_adr == adr) && (any_we || o_wb_we == we))
                ok = 1'b1;
        end
    endtask

    // Leaves the bench at the first GAP cycle after a no-action poll
    task automatic sync_gap();
        bit ok;
        repeat (30) @(negedge clk);
        wait_ack(1'b0, A_FR, 1'b0, 1'b0, 100, ok);
        chk("sync_fr_ack", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        bit ok, got;
        int fr_acks, last, lat, cnt, dr_cnt;
        int gaps[$];

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h0; rx_ready = 1'b0;
        wb_err = 1'b0; nack_dr_wr = 1'b0; fr_default = 32'h90; dr_val = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_stb", 32'(o_wb_stb), 32'd0);
        chk("rst_we", 32'(o_wb_we), 32'd0);
        chk("rst_adr", o_wb_adr, 32'h0);
        chk("rst_dat", o_wb_dat, 32'h0);
        chk("rst_sel", 32'(o_wb_sel), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_err", 32'(dut_err), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);

        // Init: first transaction is the CR write
        rst_n = 1'b1;
        wait_ack(1'b1, 32'h0, 1'b1, 1'b0, 50, ok);
        chk("init_ack", 32'(ok), 32'd1);
        chk("init_adr", o_wb_adr, A_CR);
        chk("init_we", 32'(o_wb_we), 32'd1);
        chk("init_dat", o_wb_dat, 32'h0);
        chk("init_sel", 32'(o_wb_sel), 32'hf);

        // Transmit
        sync_gap();
        push_tx(8'h41);
        chk("tx_ready_low", 32'(tx_ready), 32'd0);
        wait_ack(1'b0, A_DR, 1'b0, 1'b1, 100, ok);
        chk("tx_wr_ack", 32'(ok), 32'd1);
        chk("tx_wr_dat", o_wb_dat, 32'h0000_0041);
        chk("tx_ready_at_ack", 32'(tx_ready), 32'd0);
        @(negedge clk);
        chk("tx_ready_after_ack", 32'(tx_ready), 32'd1);
        chk("tx_cyc_after_ack", 32'(o_wb_cyc), 32'd0);

        // TX FIFO full for three polls
        sync_gap();
        fr_queue = '{32'h30, 32'h30, 32'h30, 32'h10};
        push_tx(8'h42);
        fr_acks = 0; last = 0; lat = 0; got = 1'b0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            if (o_wb_stb && wb_ack && o_wb_adr == A_FR) begin
                fr_acks++;
                if (fr_acks > 1) gaps.push_back(c - last);
                last = c;
            end else if (o_wb_stb && wb_ack && o_wb_adr == A_DR && o_wb_we) begin
                got = 1'b1;
                lat = c - last;
                chk("full_wr_dat", o_wb_dat, 32'h0000_0042);
            end
        end
        chk("full_wr_seen", 32'(got), 32'd1);
        chk("full_fr_polls", 32'(fr_acks), 32'd4);
        chk("full_gap_count", 32'(gaps.size()), 32'd3);
        foreach (gaps[i]) chk("full_poll_spacing", 32'(gaps[i]), 32'd8);
        chk("full_wr_latency", 32'(lat), 32'd3);
        dr_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_wb_stb && wb_ack && o_wb_adr == A_DR) dr_cnt++;
        end
        chk("full_single_write", 32'(dr_cnt), 32'd0);

        // Receive with backpressure
        sync_gap();
        fr_default = 32'h80;
        dr_val = 32'hffff_ff5a;
        last = 0; lat = 0; got = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if (o_wb_stb && wb_ack && o_wb_adr == A_FR) last = c;
            if (o_wb_stb && wb_ack && o_wb_adr == A_DR && !o_wb_we) begin
                got = 1'b1;
                lat = c - last;
            end
        end
        chk("rx_rd_seen", 32'(got), 32'd1);
        chk("rx_rd_latency", 32'(lat), 32'd3);
        @(negedge clk);
        chk("rx_valid", 32'(rx_valid), 32'd1);
        chk("rx_data", 32'(rx_data), 32'h5a);
        dr_cnt = 0; cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_wb_stb && wb_ack && o_wb_adr == A_DR) dr_cnt++;
            if (o_wb_stb && wb_ack && o_wb_adr == A_FR) cnt++;
        end
        chk("rx_no_read_while_full", 32'(dr_cnt), 32'd0);
        chk("rx_polls_continue", 32'(cnt > 0), 32'd1);
        chk("rx_valid_held", 32'(rx_valid), 32'd1);
        fr_default = 32'h90;
        rx_ready = 1'b1;
        @(negedge clk);
        chk("rx_valid_cleared", 32'(rx_valid), 32'd0);

        // Receive beats transmit
        sync_gap();
        fr_queue.push_back(32'h00);
        dr_val = 32'h0000_0033;
        push_tx(8'h77);
        wait_ack(1'b0, A_DR, 1'b1, 1'b0, 100, ok);
        chk("prio_first_ack", 32'(ok), 32'd1);
        chk("prio_first_is_read", 32'(o_wb_we), 32'd0);
        @(negedge clk);
        chk("prio_rx_data", 32'(rx_data), 32'h33);
        wait_ack(1'b0, A_DR, 1'b1, 1'b0, 100, ok);
        chk("prio_second_ack", 32'(ok), 32'd1);
        chk("prio_second_is_write", 32'(o_wb_we), 32'd1);
        chk("prio_wr_dat", o_wb_dat, 32'h0000_0077);

        // Timeout on a DR write, then retry
        sync_gap();
        nack_dr_wr = 1'b1;
        push_tx(8'h55);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (o_wb_stb && o_wb_we && o_wb_adr == A_DR) got = 1'b1;
            else @(negedge clk);
        end
        chk("to_stb_seen", 32'(got), 32'd1);
        cnt = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!o_wb_stb) break;
            cnt++;
        end
        chk("to_stb_cycles", 32'(cnt), 32'd255);
        chk("to_err_set", 32'(dut_err), 32'd1);
        chk("to_byte_kept", 32'(tx_ready), 32'd0);
        nack_dr_wr = 1'b0;
        wait_ack(1'b0, A_DR, 1'b0, 1'b1, 100, ok);
        chk("to_retry_ack", 32'(ok), 32'd1);
        chk("to_retry_dat", o_wb_dat, 32'h0000_0055);
        chk("to_err_sticky", 32'(dut_err), 32'd1);
        @(negedge clk);
        chk("to_tx_ready_back", 32'(tx_ready), 32'd1);

        // Reset during an active cycle
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (o_wb_stb) got = 1'b1;
        end
        chk("mid_stb_seen", 32'(got), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("mid_rst_stb", 32'(o_wb_stb), 32'd0);
        chk("mid_rst_err", 32'(dut_err), 32'd0);
        rst_n = 1'b1;
        wait_ack(1'b1, 32'h0, 1'b1, 1'b0, 50, ok);
        chk("mid_reinit_ack", 32'(ok), 32'd1);
        chk("mid_reinit_adr", o_wb_adr, A_CR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Wishbone classic-cycle initiator that drives the system UART's register file on behalf of a byte-stream client (boot monitor, debug console, or test harness). It programs the UART control register once after reset, then polls the flag register. It drains received bytes from DR into a one-entry output buffer and writes client transmit bytes to DR whenever the TX FIFO has room. It sits on the same Wishbone bus as the UART, in the master position.

## Interface
- `BASE_ADR`, 32'h1600_0000, UART register base; offsets DR=16'h0000, CR=16'h0014, FR=16'h0018 are added to it.
- `WB_DWIDTH`, 32, Wishbone data width.
- `WB_SWIDTH`, 4, Wishbone select width.
- `POLL_GAP`, 4, idle cycles between a no-action FR poll and the next poll (range 1..255).
- `TIMEOUT`, 255, cycles to wait for ack/err before abandoning a transaction (range 2..255).

Ports:
- `i_clk` in 1: single clock; one clock, all logic on its rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_tx_valid` in 1: client transmit byte valid.
- `i_tx_data` in 8: client transmit byte.
- `o_tx_ready` out 1: transmit holding register empty.
- `o_rx_valid` out 1: received byte available.
- `o_rx_data` out 8: received byte.
- `i_rx_ready` in 1: client consumes the received byte.
- `o_wb_adr` out 32, `o_wb_sel` out WB_SWIDTH, `o_wb_we` out 1, `o_wb_dat` out WB_DWIDTH, `o_wb_cyc` out 1, `o_wb_stb` out 1: Wishbone master outputs.
- `i_wb_dat` in WB_DWIDTH, `i_wb_ack` in 1, `i_wb_err` in 1: Wishbone master inputs.
- `o_err` out 1: sticky bus error/timeout flag, cleared only by reset.

## Operation
- FSM states: INIT, IDLE, POLL, DECIDE, RD_DR, WR_DR, GAP.
- **INIT**: entered from reset. Issues one write of 32'h0 to CR (all UART interrupts disabled), then goes to IDLE.
- **IDLE**: the next cycle starts POLL, a read of FR.
- **DECIDE**: evaluated from the FR value captured at ack. FR bits used: [4] RXFE, [5] TXFF.
  - If RXFE=0 and o_rx_valid=0, go to RD_DR.
  - Else if the TX holding register is full and TXFF=0, go to WR_DR.
  - Else go to GAP.
  - Receive has priority over transmit.
- **RD_DR**: read DR. At ack, load i_wb_dat[7:0] into o_rx_data and set o_rx_valid. Then go to IDLE.
- **WR_DR**: write {24'h0, tx_byte} to DR. At ack, clear the holding register. Then go to IDLE.
- **GAP**: count POLL_GAP cycles, then go to IDLE.
- **Transmit holding register**: one entry. `o_tx_ready = !tx_full`. A byte is captured when i_tx_valid && o_tx_ready.
- **Receive buffer**: o_rx_valid clears the cycle after i_rx_valid && ... specifically i_rx_ready && o_rx_valid. While o_rx_valid=1, DR is never read, so bytes back up in the UART RX FIFO.
- **Errors**: on i_wb_err, or when TIMEOUT cycles pass without ack, the transaction ends, o_err sets, and the FSM goes to GAP.
  - A failed WR_DR keeps the byte, which is retried.
  - A failed RD_DR delivers no data.
  - A failed INIT write still proceeds to IDLE.

## Timing
- Reset values:
  - o_wb_cyc, o_wb_stb, o_wb_we: 0.
  - o_wb_adr, o_wb_dat: 0.
  - o_wb_sel: 0.
  - o_rx_valid: 0; o_rx_data: 8'h0.
  - o_err: 0.
  - o_tx_ready: 1.
- Reset mid-transaction: cyc and stb are low on the first cycle after i_rst_n is sampled low, and all state is discarded.
- All Wishbone outputs are registered.
  - cyc and stb rise together with adr, we, sel=all-ones and dat stable.
  - They are held unchanged until the cycle where i_wb_ack or i_wb_err is sampled high, and deassert the following cycle.
  - At least one idle cycle (cyc=0) separates transactions.
- Read data is captured in the ack cycle.
- ack and err asserted together count as err.
- Timeout counter: starts at 1 on the first stb cycle. When it reaches TIMEOUT with no ack, stb drops the next cycle.
- With a one-wait slave (ack the cycle after stb):
  - FR stb at cycle N, ack at N+1.
  - DECIDE at N+2.
  - DR stb at N+3, ack at N+4.
  - o_rx_valid is high at N+5.
- A transmit byte accepted at cycle 0 in IDLE reaches the DR write strobe no later than cycle 4.

## Structure
- Shared package `amber_uart_pkg` holds:
  - the FSM state enum;
  - the register offsets (DR, CR, FR);
  - the FR bit indices (TXFE=7, RXFF=6, TXFF=5, RXFE=4, BUSY=3, CTS=0).
- One sub-module, `wb_single_txn`, is natural. It takes a start/adr/we/wdata request, drives cyc/stb, and handles the ack/err/timeout counter. It returns done, err and rdata pulses. The top level holds the FSM and the two data buffers.

## Test plan
- **Init:** after reset release, exactly one write occurs with adr=BASE_ADR+16'h14, dat=32'h0, sel=4'hf. No other traffic precedes it.
- **Transmit:** tx byte 8'h41 is accepted and FR returns 32'h90. The next transaction writes 32'h0000_0041 to BASE_ADR+0, and o_tx_ready returns to 1 the cycle after its ack.
- **TX full:** FR returns TXFF=1 (32'h20 with RXFE=1, i.e. 32'h30) for 3 polls, then 32'h10. Each no-action poll is followed by POLL_GAP idle cycles, and exactly one DR write follows the fourth poll.
- **Receive with backpressure:** FR=32'h80, and the DR read returns 32'hffff_ff5a. o_rx_data=8'h5a and o_rx_valid=1. While i_rx_ready=0, no further DR read is issued even though FR still reports RXFE=0.
- **Priority:** with a tx byte pending and FR=32'h00, the DR read is issued before the DR write.
- **Timeout:** the slave never acks a DR write. stb drops after 255 cycles and o_err=1 stays set. The same byte is rewritten after the gap once the slave acks again.
